seg_scan4: RTL and testbench



---
 rtl/disp_pkg.sv | 22 ++
 rtl/seg_hex_lut.sv | 10 +
 rtl/seg_scan4.sv | 121 ++++++++++++
 tb/tb_seg_scan4.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the 4-digit 7-segment scanner
package disp_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] SEL_NONE = 4'hF;

  // Active-low segment patterns, bit0 = segment a, indexed by hex value.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic        lz;
    logic [3:0]  blink;
    logic [3:0]  blank;
    logic [15:0] digits;
  } disp_cfg_t;

endpackage

// File: rtl/seg_hex_lut.sv
// rtl/seg_hex_lut.sv - combinational hex digit to active-low 7-segment decoder
module seg_hex_lut (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  import disp_pkg::*;

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan4.sv
// rtl/seg_scan4.sv - 4-digit multiplexed 7-segment scanner with blank, blink, LZ suppression
module seg_scan4 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DEAD     = 16,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic [3:0]  sel,
  output logic        frame
);
  import disp_pkg::*;

  localparam int DIV    = CLK_FREQ / SCAN_HZ;
  localparam int HALF   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        idx;
  logic [HALF_W-1:0] blink_cnt;
  logic              blink_on;
  disp_cfg_t         cfg_in;
  disp_cfg_t         pend;
  disp_cfg_t         snap;
  logic              slot_end;
  logic              frame_end;
  logic              blink_wrap;

  assign cfg_in     = {lz_en, blink, blank, digits};
  assign slot_end   = (div_cnt == DIV_W'(DIV - 1));
  assign frame_end  = slot_end && (idx == 2'd3);
  assign blink_wrap = (blink_cnt == HALF_W'(HALF - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      idx       <= 2'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap) blink_on <= ~blink_on;
    end
  end

  // A load coinciding with the frame copy goes straight into the snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      snap  <= '0;
      frame <= 1'b0;
    end else begin
      if (load) pend <= cfg_in;
      if (frame_end) snap <= load ? cfg_in : pend;
      frame <= frame_end;
    end
  end

  logic [3:0] dz;
  logic [3:0] supp;
  logic       ok3;
  logic       ok2;

  // ok3/ok2: the digit and every digit above it are suppressed or forced blank.
  always_comb begin
    for (int i = 0; i < 4; i++) dz[i] = (snap.digits[4*i +: 4] == 4'd0);
    supp    = 4'b0000;
    supp[3] = snap.lz && dz[3];
    ok3     = supp[3] || snap.blank[3];
    supp[2] = snap.lz && dz[2] && ok3;
    ok2     = (supp[2] || snap.blank[2]) && ok3;
    supp[1] = snap.lz && dz[1] && ok2;
  end

  logic [3:0] cur_hex;
  logic [6:0] lut_seg;
  logic       digit_off;
  logic [6:0] seg_d;
  logic [3:0] sel_d;

  assign cur_hex = snap.digits[4*idx +: 4];

  seg_hex_lut u_lut (
    .hex (cur_hex),
    .seg (lut_seg)
  );

  always_comb begin
    digit_off = (div_cnt < DIV_W'(DEAD))
             || snap.blank[idx]
             || (snap.blink[idx] && !blink_on)
             || supp[idx];
    seg_d = lut_seg;
    sel_d = ~(4'b0001 << idx);
    if (digit_off) begin
      seg_d = SEG_OFF;
      sel_d = SEL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_OFF;
      sel <= SEL_NONE;
    end else begin
      seg <= seg_d;
      sel <= sel_d;
    end
  end

endmodule

// File: tb/tb_seg_scan4.sv
// tb/tb_seg_scan4.sv - self-checking bench for seg_scan4
module tb_seg_scan4;

  localparam int DIV_T   = 10;
  localparam int HALF_T  = 20;
  localparam int DEAD_T  = 2;
  localparam int FRAME_T = 4 * DIV_T;

  localparam logic [6:0] HEX7 [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  blink = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic        frame;

  int vectors = 0;
  int miscompares = 0;

  seg_scan4 #(
    .CLK_FREQ (1000),
    .SCAN_HZ  (100),
    .DEAD     (2),
    .BLINK_HZ (25)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .digits (digits),
    .load   (load),
    .blank  (blank),
    .blink  (blink),
    .lz_en  (lz_en),
    .seg    (seg),
    .sel    (sel),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k counts clock edges since reset release; everything derives from it.
  int          k = 0;
  logic [24:0] pend_m = '0;
  logic [24:0] snap_m = '0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_sel = 4'hF;
  logic        exp_frame = 1'b0;

  function automatic void model_out(input int kk, input logic [24:0] s,
                                    output logic [6:0] sg, output logic [3:0] sl);
    int         di;
    int         sc;
    bit         bon;
    bit         off;
    bit         supp;
    logic [3:0] nib [4];
    di  = (kk / DIV_T) % 4;
    sc  = kk % DIV_T;
    bon = ((kk / HALF_T) % 2) == 0;
    for (int i = 0; i < 4; i++) nib[i] = s[4*i +: 4];
    supp = 1'b0;
    if (s[24] && di > 0 && nib[di] == 4'd0) begin
      supp = 1'b1;
      for (int j = di + 1; j < 4; j++)
        if (!(nib[j] == 4'd0 || s[16 + j])) supp = 1'b0;
    end
    off = (sc < DEAD_T) || s[16 + di] || (s[20 + di] && !bon) || supp;
    sg  = off ? 7'h7F : HEX7[nib[di]];
    sl  = off ? 4'hF : ~(4'b0001 << di);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      k = 0;
      pend_m = '0;
      snap_m = '0;
      exp_seg = 7'h7F;
      exp_sel = 4'hF;
      exp_frame = 1'b0;
    end else begin
      model_out(k, snap_m, exp_seg, exp_sel);
      exp_frame = (k % FRAME_T) == FRAME_T - 1;
      if (exp_frame) snap_m = load ? {lz_en, blink, blank, digits} : pend_m;
      if (load) pend_m = {lz_en, blink, blank, digits};
      k++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_seg_rst", int'(seg), 'h7F);
      chk("cyc_sel_rst", int'(sel), 'hF);
      chk("cyc_frame_rst", int'(frame), 0);
    end else begin
      chk("cyc_seg", int'(seg), int'(exp_seg));
      chk("cyc_sel", int'(sel), int'(exp_sel));
      chk("cyc_frame", int'(frame), int'(exp_frame));
    end
  end

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (frame) got = 1'b1;
    end
    chk("frame_wait", int'(got), 1);
  endtask

  // sls: slot3..slot0 select nibbles; sgs: slot3..slot0 segment patterns.
  task automatic check_frame(input logic [15:0] sls, input logic [27:0] sgs,
                             input int ld_slot, input logic [15:0] ld_d);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < DIV_T; c++) begin
        @(negedge clk);
        if (c < DEAD_T) begin
          chk($sformatf("slot%0d_dead_sel", s), int'(sel), 'hF);
          chk($sformatf("slot%0d_dead_seg", s), int'(seg), 'h7F);
        end else begin
          chk($sformatf("slot%0d_sel", s), int'(sel), int'(sls[4*s +: 4]));
          chk($sformatf("slot%0d_seg", s), int'(seg), int'(sgs[7*s +: 7]));
        end
        if (s == ld_slot && c == 4) begin
          digits = ld_d;
          load = 1'b1;
        end else begin
          load = 1'b0;
        end
      end
    end
  endtask

  task automatic release_and_check();
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk("startup_sel", int'(sel), 'hF);
        chk("startup_seg", int'(seg), 'h7F);
      end else begin
        chk("first_sel", int'(sel), 'hE);
        chk("first_seg", int'(seg), 'h40);
      end
    end
  endtask

  initial begin
    repeat (5) begin
      @(negedge clk);
      chk("hold_seg", int'(seg), 'h7F);
      chk("hold_sel", int'(sel), 'hF);
      chk("hold_frame", int'(frame), 0);
    end
    release_and_check();

    digits = 16'h1234;
    pulse_load();
    wait_frame();
    check_frame(16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, -1, 16'h0);
    check_frame(16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 1, 16'h5678);
    check_frame(16'h7BDE, {7'h12, 7'h02, 7'h78, 7'h00}, -1, 16'h0);

    lz_en = 1'b1;
    digits = 16'h0040;
    pulse_load();
    wait_frame();
    check_frame(16'hFFDE, {7'h7F, 7'h7F, 7'h19, 7'h40}, -1, 16'h0);

    digits = 16'h0000;
    pulse_load();
    wait_frame();
    check_frame(16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, -1, 16'h0);

    // Blink phase (40 cycles) is locked to the 40-cycle frame: slots 0/1 see it on, 2/3 off.
    lz_en = 1'b0;
    digits = 16'h1234;
    blank = 4'b1000;
    blink = 4'b0001;
    pulse_load();
    wait_frame();
    check_frame(16'hFBDE, {7'h7F, 7'h24, 7'h30, 7'h19}, -1, 16'h0);

    blank = 4'b0000;
    blink = 4'b0100;
    pulse_load();
    wait_frame();
    check_frame(16'h7FDE, {7'h79, 7'h7F, 7'h30, 7'h19}, -1, 16'h0);

    blink = 4'b0000;
    repeat (FRAME_T - 1) @(negedge clk);
    digits = 16'h9ABC;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("collision_frame", int'(frame), 1);
    check_frame(16'h7BDE, {7'h10, 7'h08, 7'h03, 7'h46}, -1, 16'h0);

    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_sel", int'(sel), 'hE);
    chk("pre_rst_seg", int'(seg), 'h46);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_seg", int'(seg), 'h7F);
    chk("async_rst_sel", int'(sel), 'hF);
    chk("async_rst_frame", int'(frame), 0);
    repeat (3) @(negedge clk);
    release_and_check();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
